// File: rtl/mult_seq_core_if.sv
// Operand/product handshake bundle between the register slave and the
// shift-add multiplier core.
interface mult_seq_core_if #(
   parameter int DATA_WIDTH = 32
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH-1:0]     op_a;
   logic [DATA_WIDTH-1:0]     op_b;
   logic                      is_signed;
   logic                      out_valid;
   logic                      out_ready;
   logic [2*DATA_WIDTH-1:0]   result;
   logic                      busy;
   logic [31:0]               op_count;

   modport master (
      output in_valid, op_a, op_b, is_signed, out_ready,
      input  in_ready, out_valid, result, busy, op_count
   );

   modport slave (
      input  in_valid, op_a, op_b, is_signed, out_ready,
      output in_ready, out_valid, result, busy, op_count
   );
endinterface

// File: rtl/mult_seq_core.sv
// Iterative shift-add multiplier: one partial-product bit per clock on operand
// magnitudes, sign restored in a single fix-up cycle before the product is offered.
module mult_seq_core #(
   parameter int DATA_WIDTH = 32
) (
   input  logic            ACLK,
   input  logic            ARESETN,
   mult_seq_core_if.slave  bus
);
   localparam int W     = DATA_WIDTH;
   localparam int PW    = 2 * DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state_q,    state_d;
   logic [W-1:0]      mcand_q,    mcand_d;
   logic [W-1:0]      mplier_q,   mplier_d;
   logic [PW-1:0]     acc_q,      acc_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic              neg_q,      neg_d;
   logic [PW-1:0]     result_q,   result_d;
   logic [31:0]       op_count_q, op_count_d;

   // The most-negative value negates to itself, which is its correct unsigned magnitude.
   function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic sgn);
      return (sgn && x[W-1]) ? -x : x;
   endfunction

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case infers a latch.
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      result_d   = result_q;
      op_count_d = op_count_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               mcand_d  = magnitude(bus.op_a, bus.is_signed);
               mplier_d = magnitude(bus.op_b, bus.is_signed);
               neg_d    = bus.is_signed & (bus.op_a[W-1] ^ bus.op_b[W-1]);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + (PW'(mcand_q) << cnt_q);
            end
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = FIX;
            end
         end
         FIX: begin
            result_d = neg_q ? -acc_q : acc_q;
            state_d  = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               op_count_d = op_count_q + 32'd1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= IDLE;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         result_q   <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         neg_q      <= neg_d;
         result_q   <= result_d;
         op_count_q <= op_count_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q == CALC) || (state_q == FIX);
   assign bus.result    = result_q;
   assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_mult_seq_core.sv
// Randomized and directed bench for mult_seq_core, compared every cycle against
// a timeline model built on plain integer multiplication.
module tb_mult_seq_core;
   localparam int W = 32;

   logic aclk;
   logic aresetn;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   mult_seq_core_if #(.DATA_WIDTH(W)) bus_if ();

   mult_seq_core #(.DATA_WIDTH(W)) dut (
      .ACLK    (aclk),
      .ARESETN (aresetn),
      .bus     (bus_if)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   // Model: an accepted operation shows its product W+1 edges later and is
   // retired on the first edge with out_ready; nothing else is accepted meanwhile.
   logic        m_inflight;
   int          m_age;
   logic        m_valid;
   logic [63:0] m_prod;
   logic [63:0] m_result;
   logic [31:0] m_count;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_inflight <= 1'b0;
         m_age      <= 0;
         m_valid    <= 1'b0;
         m_prod     <= '0;
         m_result   <= '0;
         m_count    <= '0;
      end else if (!m_inflight && !m_valid) begin
         if (bus_if.in_valid) begin
            m_inflight <= 1'b1;
            m_age      <= 1;
            m_prod     <= ref_mul(bus_if.op_a, bus_if.op_b, bus_if.is_signed);
         end
      end else if (m_inflight) begin
         if (m_age == W + 1) begin
            m_inflight <= 1'b0;
            m_valid    <= 1'b1;
            m_result   <= m_prod;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (bus_if.out_ready) begin
         m_valid <= 1'b0;
         m_count <= m_count + 32'd1;
      end
   end

   always @(negedge aclk) begin
      check("cmp_in_ready",  64'(bus_if.in_ready),  64'(!m_inflight && !m_valid));
      check("cmp_out_valid", 64'(bus_if.out_valid), 64'(m_valid));
      check("cmp_busy",      64'(bus_if.busy),      64'(m_inflight));
      check("cmp_result",    bus_if.result,         m_result);
      check("cmp_op_count",  64'(bus_if.op_count),  64'(m_count));
   end

   task automatic step();
      @(posedge aclk);
      #2;
   endtask

   task automatic wait_accept(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         step();
         if (!bus_if.in_ready) ok = 1'b1;
      end
      check({name, "_accept_timeout"}, 64'(ok), 64'd1);
   endtask

   task automatic wait_valid(input string name, output int lat);
      bit ok;
      lat = 0;
      ok  = bus_if.out_valid;
      while (!ok && lat < 200) begin
         step();
         lat++;
         ok = bus_if.out_valid;
      end
      check({name, "_valid_timeout"}, 64'(ok), 64'd1);
   endtask

   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      bus_if.op_a      = a;
      bus_if.op_b      = b;
      bus_if.is_signed = s;
      bus_if.in_valid  = 1'b1;
   endtask

   // Accept, scramble the operand inputs, then check latency and product.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input string name);
      int lat;
      bus_if.out_ready = 1'b1;
      drive_op(a, b, s);
      wait_accept(name);
      bus_if.in_valid  = 1'b0;
      bus_if.op_a      = $urandom;
      bus_if.op_b      = $urandom;
      bus_if.is_signed = ~s;
      wait_valid(name, lat);
      check({name, "_latency"}, 64'(lat), 64'd33);
      check({name, "_result"}, bus_if.result, exp);
      step();
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
      $fatal(1, "tb_mult_seq_core time limit");
   end

   initial begin
      logic [63:0] held;
      logic [31:0] cnt0;
      int          lat;
      int          prev_cyc;

      aresetn          = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.op_a      = '0;
      bus_if.op_b      = '0;
      bus_if.is_signed = 1'b0;
      bus_if.out_ready = 1'b0;
      #1;
      check("rst_in_ready",  64'(bus_if.in_ready),  64'd1);
      check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      check("rst_busy",      64'(bus_if.busy),      64'd0);
      check("rst_result",    bus_if.result,         64'd0);
      check("rst_op_count",  64'(bus_if.op_count),  64'd0);
      repeat (3) step();
      aresetn = 1'b1;
      step();

      run_op(32'h0000_0003, 32'h0000_0005, 1'b0, 64'h0000_0000_0000_000F, "u_3x5");
      check("u_3x5_op_count", 64'(bus_if.op_count), 64'd1);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_max");
      run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, "s_m1x2");
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_minxmin");
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, "s_minx1");

      // Backpressure: DONE holds while a competing request is ignored.
      bus_if.out_ready = 1'b0;
      drive_op(32'h0001_0000, 32'h0001_0000, 1'b0);
      wait_accept("bp");
      bus_if.in_valid = 1'b0;
      wait_valid("bp", lat);
      held = bus_if.result;
      check("bp_result", held, 64'h0000_0001_0000_0000);
      for (int k = 0; k < 20; k++) begin
         if (k == 5) drive_op(32'h0000_0007, 32'h0000_0009, 1'b0);
         step();
         check("bp_hold_result",   bus_if.result,              held);
         check("bp_hold_in_ready", 64'(bus_if.in_ready),       64'd0);
         check("bp_hold_valid",    64'(bus_if.out_valid),      64'd1);
      end
      bus_if.in_valid  = 1'b0;
      cnt0             = bus_if.op_count;
      bus_if.out_ready = 1'b1;
      step();
      check("bp_release_valid", 64'(bus_if.out_valid), 64'd0);
      check("bp_release_ready", 64'(bus_if.in_ready),  64'd1);
      check("bp_release_count", 64'(bus_if.op_count),  64'(cnt0 + 32'd1));
      step();
      check("bp_single_count",  64'(bus_if.op_count),  64'(cnt0 + 32'd1));
      check("bp_ignored_busy",  64'(bus_if.busy),      64'd0);

      // Back-to-back with in_valid and out_ready held high from a fresh reset.
      aresetn = 1'b0;
      step();
      aresetn  = 1'b1;
      step();
      prev_cyc = 0;
      drive_op(32'd1, 32'd1, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         wait_accept("b2b");
         if (i < 4) drive_op(32'(i + 1), 32'(i + 1), 1'b0);
         else       bus_if.in_valid = 1'b0;
         wait_valid("b2b", lat);
         check("b2b_result", bus_if.result, 64'(i * i));
         if (i > 1) check("b2b_spacing", 64'(cyc - prev_cyc), 64'd35);
         prev_cyc = cyc;
      end
      step();
      check("b2b_op_count", 64'(bus_if.op_count), 64'd4);

      // Asynchronous reset ten cycles into CALC discards the operation.
      drive_op(32'h0000_DEAD, 32'h0000_BEEF, 1'b0);
      wait_accept("mid_rst");
      bus_if.in_valid = 1'b0;
      repeat (10) step();
      aresetn = 1'b0;
      #1;
      check("mid_rst_in_ready",  64'(bus_if.in_ready),  64'd1);
      check("mid_rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      check("mid_rst_busy",      64'(bus_if.busy),      64'd0);
      check("mid_rst_result",    bus_if.result,         64'd0);
      check("mid_rst_op_count",  64'(bus_if.op_count),  64'd0);
      step();
      aresetn = 1'b1;
      run_op(32'd7, 32'd6, 1'b0, 64'h2A, "post_rst");
      check("post_rst_op_count", 64'(bus_if.op_count), 64'd1);

      // Random traffic: idle gaps, ignored requests while busy, output stalls.
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) step();
         bus_if.out_ready = 1'($urandom_range(0, 1));
         drive_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
         wait_accept("rnd");
         bus_if.in_valid = 1'($urandom_range(0, 1));
         bus_if.op_a     = $urandom;
         bus_if.op_b     = $urandom;
         wait_valid("rnd", lat);
         check("rnd_latency", 64'(lat), 64'd33);
         bus_if.in_valid = 1'b0;
         repeat ($urandom_range(0, 4)) step();
         bus_if.out_ready = 1'b1;
         step();
         bus_if.out_ready = 1'b0;
      end
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
